// File: rtl/wrapper_ahb_packet_initiator.sv
// wrapper_ahb_packet_initiator: writes each stream packet as an AHB-Lite INCR word burst into a wrapper input-port window.
// Define WRAPPER_AHB_INITIATOR_DATA_REQ_EN to add data_req and gate packet acceptance on it.
module wrapper_ahb_packet_initiator #(
  parameter int ADDRWIDTH = 12,
  parameter int PORTADDRWIDTH = 10,
  parameter int PACKETWIDTH = 512,
  parameter logic [ADDRWIDTH-1:0] BASEADDR = '0
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic [PACKETWIDTH-1:0] packet_data,
  input  logic packet_data_last,
  input  logic packet_data_valid,
  output logic packet_data_ready,
  output logic [ADDRWIDTH-1:0] HADDRM,
  output logic [1:0] HTRANSM,
  output logic [2:0] HSIZEM,
  output logic [2:0] HBURSTM,
  output logic HWRITEM,
  output logic [31:0] HWDATAM,
  input  logic HREADYM,
  input  logic HRESPM,
  input  logic err_clear,
`ifdef WRAPPER_AHB_INITIATOR_DATA_REQ_EN
  input  logic data_req,
`endif
  output logic busy,
  output logic err
);
  localparam int BEATS = PACKETWIDTH / 32;
  localparam int BW = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [ADDRWIDTH-1:0] SLOT = ADDRWIDTH'((1 << PORTADDRWIDTH) - PACKETWIDTH / 8);
  typedef enum logic [1:0] {IDLE, XFER, LAST, ERR} state_t;
  state_t state, next;
  logic [BEATS-1:0][31:0] pkt;
  logic [BW-1:0] beat;
  logic last_r, out_en, accept, err_hit;
  assign HSIZEM = 3'b010;
  assign HBURSTM = 3'b001;
  assign HWRITEM = HTRANSM[1];
  assign busy = state != IDLE;
  assign HADDRM = BASEADDR + (last_r ? SLOT : '0) + ADDRWIDTH'({beat, 2'b00});
`ifdef WRAPPER_AHB_INITIATOR_DATA_REQ_EN
  assign packet_data_ready = state == IDLE && out_en && data_req;
`else
  assign packet_data_ready = state == IDLE && out_en;
`endif
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) state <= IDLE;
    else state <= next;
  // First error cycle drops the pending address phase in the same cycle.
  always_comb begin
    accept = packet_data_valid && packet_data_ready;
    err_hit = (state == XFER || state == LAST) && HRESPM && !HREADYM;
    HTRANSM = state == XFER && !err_hit ? (beat == '0 ? 2'b10 : 2'b11) : 2'b00;
    next = err_hit ? ERR :
           state == IDLE ? (accept ? XFER : IDLE) :
           state == XFER ? (HREADYM && beat == LAST_BEAT ? LAST : XFER) :
           HREADYM ? IDLE : state;
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      out_en <= 1'b0;
      err <= 1'b0;
      pkt <= '0;
      last_r <= 1'b0;
      beat <= '0;
      HWDATAM <= '0;
    end else begin
      out_en <= 1'b1;
      err <= err_clear ? 1'b0 : err_hit ? 1'b1 : err;
      if (accept) begin
        pkt <= packet_data;
        last_r <= packet_data_last;
        beat <= '0;
      end
      if (state == XFER && HREADYM) begin
        HWDATAM <= pkt[beat];
        if (beat != LAST_BEAT) beat <= beat + BW'(1);
      end
    end
endmodule

// File: tb/tb_wrapper_ahb_packet_initiator.sv
// tb_wrapper_ahb_packet_initiator: cycle-by-cycle vector table plus reset and data_req sequences.
module tb_wrapper_ahb_packet_initiator;
  localparam int BEATS = 16;
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic [511:0] packet_data = '0;
  logic packet_data_last = 1'b0, packet_data_valid = 1'b0, packet_data_ready;
  logic [11:0] HADDRM;
  logic [1:0] HTRANSM;
  logic [2:0] HSIZEM, HBURSTM;
  logic HWRITEM;
  logic [31:0] HWDATAM;
  logic HREADYM = 1'b1, HRESPM = 1'b0, err_clear = 1'b0, busy, err;
`ifdef WRAPPER_AHB_INITIATOR_DATA_REQ_EN
  logic data_req = 1'b1;
`endif
  int checks = 0, failures = 0;

  wrapper_ahb_packet_initiator dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .packet_data(packet_data), .packet_data_last(packet_data_last),
    .packet_data_valid(packet_data_valid), .packet_data_ready(packet_data_ready),
    .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HSIZEM(HSIZEM), .HBURSTM(HBURSTM),
    .HWRITEM(HWRITEM), .HWDATAM(HWDATAM), .HREADYM(HREADYM), .HRESPM(HRESPM),
    .err_clear(err_clear),
`ifdef WRAPPER_AHB_INITIATOR_DATA_REQ_EN
    .data_req(data_req),
`endif
    .busy(busy), .err(err)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic valid, last, hready, hresp, clr, dreq;
    logic [7:0] seed;
    logic [1:0] trans;
    logic [11:0] addr;
    logic wchk;
    logic [31:0] wdata;
    logic busy, ready, err;
  } vec_t;
  vec_t vq[$];

  function automatic logic [31:0] word(input logic [7:0] seed, input int k);
    return {seed, 16'h0000, 8'(k)};
  endfunction

  function automatic logic [511:0] pkt_of(input logic [7:0] seed);
    logic [511:0] p;
    for (int k = 0; k < BEATS; k++) p[32*k +: 32] = word(seed, k);
    return p;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%h exp=%h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic valid, last, hready, hresp, clr, input logic [7:0] seed,
                     input logic [1:0] trans, input logic [11:0] addr, input logic wchk,
                     input logic [31:0] wdata, input logic b, r, e);
    vec_t v;
    v.valid = valid; v.last = last; v.hready = hready; v.hresp = hresp; v.clr = clr;
    v.dreq = 1'b1; v.seed = seed; v.trans = trans; v.addr = addr; v.wchk = wchk;
    v.wdata = wdata; v.busy = b; v.ready = r; v.err = e;
    vq.push_back(v);
  endtask

  // Accept cycle plus BEATS+1 cycles; the caller appends the cycle that is back in IDLE.
  task automatic gen_burst(input logic [7:0] seed, input logic last, input int wait_beat,
                           input int nwaits, input logic e);
    logic [11:0] base, a;
    logic [1:0] t;
    base = last ? 12'h3C0 : 12'h000;
    add(1'b1, last, 1'b1, 1'b0, 1'b0, seed, 2'b00, 12'h000, 1'b0, 32'h0, 1'b0, 1'b1, e);
    for (int c = 1; c <= BEATS + 1; c++) begin
      t = c > BEATS ? 2'b00 : c == 1 ? 2'b10 : 2'b11;
      a = base + 12'(4 * (c - 1));
      if (c - 2 == wait_beat)
        for (int n = 0; n < nwaits; n++)
          add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, seed, t, a, c >= 2, word(seed, c - 2), 1'b1, 1'b0, e);
      add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, seed, t, a, c >= 2, word(seed, c - 2), 1'b1, 1'b0, e);
    end
  endtask

  task automatic idle_vec(input logic r, input logic e);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 12'h000, 1'b0, 32'h0, 1'b0, r, e);
  endtask

  task automatic run();
    foreach (vq[i]) begin
      packet_data_valid = vq[i].valid;
      packet_data_last = vq[i].last;
      packet_data = pkt_of(vq[i].seed);
      HREADYM = vq[i].hready;
      HRESPM = vq[i].hresp;
      err_clear = vq[i].clr;
`ifdef WRAPPER_AHB_INITIATOR_DATA_REQ_EN
      data_req = vq[i].dreq;
`endif
      @(negedge HCLK);
      chk("htrans", i, 32'(HTRANSM), 32'(vq[i].trans));
      chk("hwrite", i, 32'(HWRITEM), 32'(vq[i].trans != 2'b00));
      chk("busy", i, 32'(busy), 32'(vq[i].busy));
      chk("ready", i, 32'(packet_data_ready), 32'(vq[i].ready));
      chk("err", i, 32'(err), 32'(vq[i].err));
      if (vq[i].trans != 2'b00) chk("haddr", i, 32'(HADDRM), 32'(vq[i].addr));
      if (vq[i].wchk) chk("hwdata", i, HWDATAM, vq[i].wdata);
      @(posedge HCLK); #1;
    end
  endtask

  initial begin
    // Vector table: zero-wait bursts, back-to-back last packet, wait states, errors.
    gen_burst(8'h00, 1'b0, 99, 0, 1'b0);
    gen_burst(8'h11, 1'b1, 99, 0, 1'b0);
    idle_vec(1'b1, 1'b0);
    gen_burst(8'h22, 1'b0, 3, 2, 1'b0);
    idle_vec(1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33, 2'b00, 12'h000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 6; c++)
      add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33, c == 1 ? 2'b10 : 2'b11, 12'(4 * (c - 1)),
          c >= 2, word(8'h33, c - 2), 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 2'b00, 12'h000, 1'b1, word(8'h33, 5), 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h33, 2'b00, 12'h000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    idle_vec(1'b1, 1'b1);
    idle_vec(1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 2'b00, 12'h000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    idle_vec(1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44, 2'b00, 12'h000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44, 2'b10, 12'h000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 2'b00, 12'h000, 1'b1, word(8'h44, 0), 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h44, 2'b00, 12'h000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle_vec(1'b1, 1'b0);

    // Reset values while HRESETn is held low.
    #12;
    chk("rst_htrans", -1, 32'(HTRANSM), 32'h0);
    chk("rst_haddr", -1, 32'(HADDRM), 32'h0);
    chk("rst_hwdata", -1, HWDATAM, 32'h0);
    chk("rst_hwrite", -1, 32'(HWRITEM), 32'h0);
    chk("rst_busy", -1, 32'(busy), 32'h0);
    chk("rst_err", -1, 32'(err), 32'h0);
    chk("rst_ready", -1, 32'(packet_data_ready), 32'h0);
    chk("hsize", -1, 32'(HSIZEM), 32'h2);
    chk("hburst", -1, 32'(HBURSTM), 32'h1);
    #10 HRESETn = 1'b1;
    @(posedge HCLK); #1;
    run();

    // Reset asserted during the beat 8 address phase.
    packet_data_valid = 1'b1;
    packet_data_last = 1'b0;
    packet_data = pkt_of(8'h55);
    HREADYM = 1'b1;
    HRESPM = 1'b0;
    err_clear = 1'b0;
    @(posedge HCLK); #1;
    packet_data_valid = 1'b0;
    repeat (8) @(posedge HCLK);
    #1;
    chk("pre_htrans", -1, 32'(HTRANSM), 32'h3);
    chk("pre_haddr", -1, 32'(HADDRM), 32'h020);
    #2 HRESETn = 1'b0;
    #1;
    chk("mid_htrans", -1, 32'(HTRANSM), 32'h0);
    chk("mid_busy", -1, 32'(busy), 32'h0);
    chk("mid_haddr", -1, 32'(HADDRM), 32'h0);
    chk("mid_hwdata", -1, HWDATAM, 32'h0);
    chk("mid_ready", -1, 32'(packet_data_ready), 32'h0);
    @(posedge HCLK); #2 HRESETn = 1'b1;
    #1;
    chk("rel_ready0", -1, 32'(packet_data_ready), 32'h0);
    @(posedge HCLK);
    @(negedge HCLK);
    chk("rel_ready1", -1, 32'(packet_data_ready), 32'h1);
    chk("rel_busy", -1, 32'(busy), 32'h0);
    chk("rel_htrans", -1, 32'(HTRANSM), 32'h0);
    @(posedge HCLK); #1;

`ifdef WRAPPER_AHB_INITIATOR_DATA_REQ_EN
    // data_req gating: no accept while low, accept when high, ignored mid-burst.
    vq.delete();
    for (int n = 0; n < 10; n++) begin
      add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h66, 2'b00, 12'h000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      vq[vq.size() - 1].dreq = 1'b0;
    end
    gen_burst(8'h66, 1'b0, 99, 0, 1'b0);
    for (int n = 15; n < vq.size(); n++) vq[n].dreq = 1'b0;
    idle_vec(1'b0, 1'b0);
    vq[vq.size() - 1].dreq = 1'b0;
    run();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
